// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message loader: FSM encoding and padding constants.
package sha1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PAD    = 3'd2,
        ST_LEN_HI = 3'd3,
        ST_LEN_LO = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // First padding byte appended after the message.
    localparam logic [7:0] PAD_BYTE = 8'h80;
    // Byte offset inside a 64-byte block where the 64-bit length begins.
    localparam logic [5:0] LEN_POS = 6'd56;
    localparam int WORDS_PER_BLOCK = 16;
    // Shift that turns a byte count into a block count.
    localparam int BLK_SHIFT = $clog2(WORDS_PER_BLOCK * 4);

endpackage

// File: rtl/sha1_byte_packer.sv
// Big-endian byte-to-word packer: holds the three leading bytes of a word and
// emits the full word in the same cycle its fourth byte arrives.
module sha1_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    // The fourth byte is never stored; it is combined directly into word.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  lane_q, lane_d;

    // Next-state: clear on a new message, shift in accepted bytes, otherwise hold.
    always_comb begin
        shift_d = shift_q;
        lane_d  = lane_q;
        if (clr) begin
            shift_d = 24'h000000;
            lane_d  = 2'd0;
        end else if (byte_valid) begin
            shift_d = {shift_q[15:0], byte_in};
            lane_d  = lane_q + 2'd1;
        end else begin
            shift_d = shift_q;
            lane_d  = lane_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= 24'h000000;
            lane_q  <= 2'd0;
        end else begin
            shift_q <= shift_d;
            lane_q  <= lane_d;
        end
    end

    assign word_valid = byte_valid && !clr && (lane_q == 2'd3);
    assign word       = {shift_q, byte_in};

endmodule

// File: rtl/sha1_msg_loader.sv
// SHA-1 message loader: packs an input byte stream into 32-bit words, appends
// SHA-1 padding and the bit length, and writes the result into message RAM.
module sha1_msg_loader
    import sha1_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    output logic [ADDR_W-4:0] nblocks,
    output logic              done_o,
    output logic              err
);

    // Byte counter is wide enough to hold the full RAM capacity in bytes.
    localparam int NB_W      = ADDR_W + 3;
    // Accepting this many bytes without room for padding is an overflow.
    localparam int OVF_LIMIT = 2 ** (ADDR_W + 2) - 8;

    state_e            state_q, state_d;
    logic [NB_W-1:0]   nb_q, nb_d;
    logic [NB_W-1:0]   len_q, len_d;
    logic              pad_first_q, pad_first_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic [ADDR_W-4:0] nblocks_q, nblocks_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              pk_clr_s, pk_valid_s, pk_word_valid_s;
    logic [7:0]        pk_byte_s;
    logic [31:0]       pk_word_s;
    logic [NB_W-1:0]   nb_inc_s, nb_p4_s;

    sha1_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pk_clr_s),
        .byte_valid (pk_valid_s),
        .byte_in    (pk_byte_s),
        .word_valid (pk_word_valid_s),
        .word       (pk_word_s)
    );

    assign nb_inc_s = nb_q + NB_W'(1);
    assign nb_p4_s  = nb_q + NB_W'(4);

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        nb_d        = nb_q;
        len_d       = len_q;
        pad_first_d = pad_first_q;
        in_ready_d  = in_ready_q;
        ram_waddr_d = ram_waddr_q;
        ram_we_d    = 1'b0;
        ram_din_d   = ram_din_q;
        nblocks_d   = nblocks_q;
        done_d      = 1'b0;
        err_d       = err_q;
        pk_clr_s    = 1'b0;
        pk_valid_s  = 1'b0;
        pk_byte_s   = in_data;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    nb_d        = {NB_W{1'b0}};
                    err_d       = 1'b0;
                    nblocks_d   = {(ADDR_W-3){1'b0}};
                    ram_waddr_d = {ADDR_W{1'b0}};
                    in_ready_d  = 1'b1;
                    pk_clr_s    = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    pk_valid_s = 1'b1;
                    nb_d       = nb_inc_s;
                    if (nb_inc_s == NB_W'(OVF_LIMIT)) begin
                        // No room left for padding: abandon the message.
                        state_d    = ST_DONE;
                        err_d      = 1'b1;
                        done_d     = 1'b1;
                        nblocks_d  = {(ADDR_W-3){1'b0}};
                        in_ready_d = 1'b0;
                    end else begin
                        if (pk_word_valid_s) begin
                            ram_we_d    = 1'b1;
                            ram_waddr_d = nb_q[ADDR_W+1:2];
                            ram_din_d   = pk_word_s;
                        end else begin
                            ram_we_d = 1'b0;
                        end
                        if (in_last) begin
                            state_d     = ST_PAD;
                            in_ready_d  = 1'b0;
                            len_d       = nb_inc_s;
                            pad_first_d = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_PAD: begin
                pk_valid_s  = 1'b1;
                pk_byte_s   = pad_first_q ? PAD_BYTE : 8'h00;
                pad_first_d = 1'b0;
                nb_d        = nb_inc_s;
                if (pk_word_valid_s) begin
                    ram_we_d    = 1'b1;
                    ram_waddr_d = nb_q[ADDR_W+1:2];
                    ram_din_d   = pk_word_s;
                end else begin
                    ram_we_d = 1'b0;
                end
                if (nb_inc_s[5:0] == LEN_POS) begin
                    state_d = ST_LEN_HI;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_LEN_HI: begin
                // Upper 32 bits of the bit length are always zero at this capacity.
                ram_we_d    = 1'b1;
                ram_waddr_d = nb_q[ADDR_W+1:2];
                ram_din_d   = 32'h00000000;
                nb_d        = nb_p4_s;
                state_d     = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                ram_we_d    = 1'b1;
                ram_waddr_d = nb_q[ADDR_W+1:2];
                ram_din_d   = 32'({len_q, 3'b000});
                nb_d        = nb_p4_s;
                nblocks_d   = nb_p4_s[BLK_SHIFT +: (ADDR_W-3)];
                done_d      = 1'b1;
                state_d     = ST_DONE;
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            nb_q        <= {NB_W{1'b0}};
            len_q       <= {NB_W{1'b0}};
            pad_first_q <= 1'b0;
            in_ready_q  <= 1'b0;
            ram_waddr_q <= {ADDR_W{1'b0}};
            ram_we_q    <= 1'b0;
            ram_din_q   <= 32'h00000000;
            nblocks_q   <= {(ADDR_W-3){1'b0}};
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nb_q        <= nb_d;
            len_q       <= len_d;
            pad_first_q <= pad_first_d;
            in_ready_q  <= in_ready_d;
            ram_waddr_q <= ram_waddr_d;
            ram_we_q    <= ram_we_d;
            ram_din_q   <= ram_din_d;
            nblocks_q   <= nblocks_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_we    = ram_we_q;
    assign ram_din   = ram_din_q;
    assign nblocks   = nblocks_q;
    assign done_o    = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sha1_msg_loader.sv
// Self-checking bench for sha1_msg_loader: random byte streams with valid gaps,
// compared against a padded-message reference built from SHA-1 padding rules.
module tb_sha1_msg_loader;

    localparam int ADDR_W = 7;
    localparam int NW     = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_we;
    logic [31:0]       ram_din;
    logic [ADDR_W-4:0] nblocks;
    logic              done_o;
    logic              err;

    sha1_msg_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ram_waddr (ram_waddr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .nblocks   (nblocks),
        .done_o    (done_o),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Message RAM with per-word write stamps so stale data is never mistaken for fresh.
    logic [31:0] mem [NW];
    int          wr_epoch [NW];
    int          epoch     = 0;
    int          wr_cnt    = 0;
    int          hi_wr     = 0;
    int          done_cyc  = 0;

    // RAM write port and activity counters.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr]      <= ram_din;
            wr_epoch[ram_waddr] <= epoch;
            wr_cnt              <= wr_cnt + 1;
            if (int'(ram_waddr) >= NW - 2) hi_wr <= hi_wr + 1;
        end
        if (done_o) done_cyc <= done_cyc + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    // Reference model: message bytes and the expected padded word image.
    logic [7:0]  msg   [512];
    logic [31:0] exp_w [NW];
    int          exp_nb;

    task automatic build_expected(input int len);
        logic [7:0]  p [512];
        logic [63:0] lbits;
        int          t;
        t     = ((len + 9 + 63) / 64) * 64;
        lbits = 64'(len) * 64'd8;
        for (int i = 0; i < 512; i++)
            p[i] = (i < len) ? msg[i] : ((i == len) ? 8'h80 : 8'h00);
        for (int j = 0; j < 8; j++)
            p[t - 8 + j] = lbits[8*(7-j) +: 8];
        exp_nb = t / 64;
        for (int k = 0; k < NW; k++)
            exp_w[k] = {p[4*k], p[4*k+1], p[4*k+2], p[4*k+3]};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_msg(input int len, input int gap_pct, input bit with_last);
        for (int i = 0; i < len; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = with_last && (i == len - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("done_seen", 32'(done_o), 32'd1);
    endtask

    task automatic run_check(input string name, input int len, input int gap_pct);
        int w0, d0;
        epoch++;
        w0 = wr_cnt;
        d0 = done_cyc;
        build_expected(len);
        pulse_start();
        check_val({name, "_start_err"}, 32'(err), 32'd0);
        send_msg(len, gap_pct, 1'b1);
        check_val({name, "_rdy_drop"}, 32'(in_ready), 32'd0);
        wait_done();
        check_val({name, "_nblocks"}, 32'(nblocks), 32'(exp_nb));
        check_val({name, "_err"}, 32'(err), 32'd0);
        @(posedge clk); #1;
        check_val({name, "_done_low"}, 32'(done_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_val({name, "_done_cyc"}, 32'(done_cyc - d0), 32'd1);
        check_val({name, "_wr_cnt"}, 32'(wr_cnt - w0), 32'(exp_nb * 16));
        for (int k = 0; k < exp_nb * 16; k++)
            check_val($sformatf("%s_w%0d", name, k),
                      (wr_epoch[k] == epoch) ? mem[k] : 32'hxxxxxxxx, exp_w[k]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, h0, d0, w0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_din", ram_din, 32'h00000000);
        check_val("rst_outs", 32'({in_ready, ram_we, done_o, err, nblocks, ram_waddr}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // "abc"
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_check("abc", 3, 0);
        check_val("abc_w0_const", mem[0], 32'h61626380);
        check_val("abc_w15_const", mem[15], 32'h00000018);

        // 55 bytes: 0x80 fits in the first block
        for (int i = 0; i < 55; i++) msg[i] = 8'(i);
        run_check("l55", 55, 0);
        check_val("l55_w13_const", mem[13], 32'h34353680);
        check_val("l55_w15_const", mem[15], 32'h000001B8);

        // 56 bytes: padding spills into a second block
        for (int i = 0; i < 56; i++) msg[i] = 8'(i);
        run_check("l56", 56, 0);
        check_val("l56_w31_const", mem[31], 32'h000001C0);

        // Maximum legal length with random data and gaps
        for (int i = 0; i < 503; i++) msg[i] = 8'($urandom);
        run_check("l503", 503, 30);
        check_val("l503_w127_const", mem[127], 32'h00000FB8);

        // Random lengths
        for (int r = 0; r < 4; r++) begin
            len = int'($urandom_range(503, 1));
            for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
            run_check($sformatf("rnd%0d", r), len, 20);
        end

        // Overflow: 504 bytes with no last
        epoch++;
        h0 = hi_wr;
        d0 = done_cyc;
        for (int i = 0; i < 504; i++) msg[i] = 8'($urandom);
        pulse_start();
        send_msg(504, 10, 1'b0);
        check_val("ovf_err", 32'(err), 32'd1);
        wait_done();
        check_val("ovf_nblocks", 32'(nblocks), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_val("ovf_err_sticky", 32'(err), 32'd1);
        check_val("ovf_done_cyc", 32'(done_cyc - d0), 32'd1);
        check_val("ovf_hi_wr", 32'(hi_wr - h0), 32'd0);
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_check("ovf_abc", 3, 0);

        // Asynchronous reset in the middle of a message
        epoch++;
        for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
        pulse_start();
        send_msg(10, 0, 1'b0);
        rst = 1'b1;
        #1;
        check_val("arst_din", ram_din, 32'h00000000);
        check_val("arst_outs", 32'({in_ready, ram_we, done_o, err, nblocks, ram_waddr}), 32'd0);
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        check_val("arst_no_wr", 32'(wr_cnt - w0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_check("arst_abc", 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
